// File: rtl/font_row_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : font_row_fetcher
// Purpose  : Reads one 16-pixel glyph row out of a 1-bit-wide font ROM and
//            presents it as a parallel pixel word over a valid/ready handshake.
//            Addresses are offset + row*GLYPH_W + column, wrapping mod 8192.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_50MHz  in   system clock
//   rst_n      in   asynchronous active-low reset
//   req        in   fetch request (sampled only while idle)
//   offset     in   13-bit glyph base bit-address
//   row        in   glyph row index
//   busy       out  high from request acceptance until handshake completes
//   rom_addr   out  font ROM bit address (holds its last value when not fetching)
//   rom_data   in   font ROM data, valid ROM_LAT clocks after rom_addr
//   row_bits   out  assembled row, MSB = leftmost pixel (column 0)
//   row_valid  out  row_bits valid
//   row_ready  in   downstream accepts row_bits
// ============================================================================
module font_row_fetcher #(
    parameter int GLYPH_W = 16,
    parameter int GLYPH_H = 32,
    parameter int ROM_LAT = 1
) (
    input  logic               clk_50MHz,
    input  logic               rst_n,
    input  logic               req,
    input  logic [12:0]        offset,
    input  logic [4:0]         row,
    output logic               busy,
    output logic [12:0]        rom_addr,
    input  logic               rom_data,
    output logic [GLYPH_W-1:0] row_bits,
    output logic               row_valid,
    input  logic               row_ready
);

    localparam int                 c_col_w      = $clog2(GLYPH_W);
    localparam int                 c_glyph_bits = GLYPH_W * GLYPH_H;
    localparam logic [c_col_w-1:0] c_last_col   = c_col_w'(GLYPH_W - 1);

    generate
        if (ROM_LAT < 1 || ROM_LAT > 3) begin : g_bad_rom_lat
            $error("font_row_fetcher: ROM_LAT must be 1..3");
        end
        if (c_glyph_bits > 8192) begin : g_bad_glyph_size
            $error("font_row_fetcher: glyph does not fit the 13-bit ROM space");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_col_w-1:0] r_col;
    logic               r_pipe_vld [ROM_LAT];
    logic [c_col_w-1:0] r_pipe_col [ROM_LAT];
    logic               w_pipe_busy;
    logic [12:0]        w_row_base;

    // Column 0 address; later columns are reached by incrementing rom_addr,
    // which gives the same modulo-8192 result as adding the column index.
    assign w_row_base = offset + (13'(row) * 13'(GLYPH_W));

    always_comb begin
        w_pipe_busy = 1'b0;
        for (int i = 0; i < ROM_LAT; i++) begin
            w_pipe_busy = w_pipe_busy | r_pipe_vld[i];
        end
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and handshake outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b1;
        row_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (req) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (r_col == c_last_col) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // Capture pipeline drained: final column is in row_bits.
                if (!w_pipe_busy) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                row_valid = 1'b1;
                if (row_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Address generation and column counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr <= 13'd0;
            r_col    <= '0;
        end else if (r_state == S_IDLE && req) begin
            rom_addr <= w_row_base;
            r_col    <= '0;
        end else if (r_state == S_FETCH) begin
            r_col <= r_col + c_col_w'(1);
            if (r_col != c_last_col) begin
                rom_addr <= rom_addr + 13'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Capture pipeline: tracks which column the ROM is returning ROM_LAT
    // clocks after its address was presented. Cleared on reset so that any
    // read still in flight is dropped.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ROM_LAT; i++) begin
                r_pipe_vld[i] <= 1'b0;
                r_pipe_col[i] <= '0;
            end
        end else begin
            r_pipe_vld[0] <= (r_state == S_FETCH);
            r_pipe_col[0] <= r_col;
            for (int i = 1; i < ROM_LAT; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_col[i] <= r_pipe_col[i-1];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Row assembly: column c lands in bit GLYPH_W-1-c (leftmost pixel = MSB)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            row_bits <= '0;
        end else if (r_state == S_IDLE && req) begin
            row_bits <= '0;
        end else if (r_pipe_vld[ROM_LAT-1]) begin
            row_bits[c_last_col - r_pipe_col[ROM_LAT-1]] <= rom_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_font_row_fetcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_font_row_fetcher
// Purpose  : Self-checking bench for font_row_fetcher. Two instances are
//            exercised, one with ROM_LAT=1 and one with ROM_LAT=3, each fed
//            by a latency-matched model of the font ROM. Expected rows are
//            computed directly from ROM contents and the address rule.
// Revision : 1.0  initial release
// ============================================================================
module tb_font_row_fetcher;

    localparam int c_w = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [12:0] offset = '0;
    logic [4:0]  row = '0;
    logic        row_ready = 1'b0;

    logic        req1 = 1'b0, req3 = 1'b0;
    logic        busy1, busy3, valid1, valid3, rd1, rd3;
    logic [12:0] addr1, addr3;
    logic [15:0] bits1, bits3;

    logic        mem [0:8191];
    logic [12:0] ap1;
    logic [12:0] ap3 [3];

    int n_cmp = 0;
    int n_err = 0;

    always #10 clk = ~clk;

    font_row_fetcher #(.GLYPH_W(16), .GLYPH_H(32), .ROM_LAT(1)) u_dut1 (
        .clk_50MHz(clk), .rst_n(rst_n), .req(req1), .offset(offset), .row(row),
        .busy(busy1), .rom_addr(addr1), .rom_data(rd1), .row_bits(bits1),
        .row_valid(valid1), .row_ready(row_ready)
    );

    font_row_fetcher #(.GLYPH_W(16), .GLYPH_H(32), .ROM_LAT(3)) u_dut3 (
        .clk_50MHz(clk), .rst_n(rst_n), .req(req3), .offset(offset), .row(row),
        .busy(busy3), .rom_addr(addr3), .rom_data(rd3), .row_bits(bits3),
        .row_valid(valid3), .row_ready(row_ready)
    );

    // Font ROM models: registered reads with 1 and 3 clocks of latency
    always @(posedge clk) begin
        ap1    <= addr1;
        ap3[0] <= addr3;
        ap3[1] <= ap3[0];
        ap3[2] <= ap3[1];
    end
    assign rd1 = mem[ap1];
    assign rd3 = mem[ap3[2]];

    // ---------------------------------------------------------------- model
    function automatic int pix_addr(input logic [12:0] off, input logic [4:0] r, input int c);
        return (int'(off) + int'(r) * c_w + c) % 8192;
    endfunction

    function automatic logic [15:0] model_row(input logic [12:0] off, input logic [4:0] r);
        logic [15:0] v;
        for (int c = 0; c < c_w; c++) begin
            v[15-c] = mem[pix_addr(off, r, c)];
        end
        return v;
    endfunction

    // mode 0: bit = addr[0], 1: all ones, 2: all zeros, 3: random
    task automatic fill_mem(input int mode);
        for (int a = 0; a < 8192; a++) begin
            case (mode)
                0:       mem[a] = a[0];
                1:       mem[a] = 1'b1;
                2:       mem[a] = 1'b0;
                default: mem[a] = 1'($urandom);
            endcase
        end
    endtask

    task automatic set_req(input bit use3, input logic v);
        if (use3) req3 = v;
        else      req1 = v;
    endtask

    // One complete fetch on the selected instance. Sampling happens on the
    // falling edge after rising edge k (edge 0 accepts the request).
    // ready_edge: first rising edge at which row_ready is high.
    // req2_edge : rising edge at which an extra request is presented (0 = none).
    task automatic fetch_check(input bit use3, input logic [12:0] off, input logic [4:0] r,
                               input int ready_edge, input int req2_edge, input string tag);
        int          lat;
        int          valid_edge;
        int          h;
        logic [15:0] exp_bits;
        logic [12:0] exp_addr;
        logic        b, v;
        logic [12:0] a;
        logic [15:0] bits;
        lat        = use3 ? 3 : 1;
        valid_edge = 17 + lat;
        h          = (ready_edge > valid_edge + 1) ? ready_edge : valid_edge + 1;
        exp_bits   = model_row(off, r);

        @(negedge clk);
        offset    = off;
        row       = r;
        row_ready = (ready_edge <= 0);
        set_req(use3, 1'b1);
        @(negedge clk);
        for (int k = 0; k <= h + 2; k++) begin
            if (k == 0) begin
                offset = 13'($urandom);
                row    = 5'($urandom);
            end
            set_req(use3, (req2_edge > 0) && (k + 1 == req2_edge));
            row_ready = (k + 1 >= ready_edge);

            b    = use3 ? busy3  : busy1;
            v    = use3 ? valid3 : valid1;
            a    = use3 ? addr3  : addr1;
            bits = use3 ? bits3  : bits1;
            exp_addr = 13'(pix_addr(off, r, (k < 16) ? k : 15));

            n_cmp++;
            if (a !== exp_addr) begin
                n_err++;
                $display("FAIL %s rom_addr edge %0d: got %h want %h", tag, k, a, exp_addr);
            end
            n_cmp++;
            if (b !== (k < h)) begin
                n_err++;
                $display("FAIL %s busy edge %0d: got %b want %b", tag, k, b, (k < h));
            end
            n_cmp++;
            if (v !== (k >= valid_edge && k < h)) begin
                n_err++;
                $display("FAIL %s row_valid edge %0d: got %b want %b", tag, k, v,
                         (k >= valid_edge && k < h));
            end
            if (k >= valid_edge) begin
                n_cmp++;
                if (bits !== exp_bits) begin
                    n_err++;
                    $display("FAIL %s row_bits edge %0d: got %h want %h", tag, k, bits, exp_bits);
                end
            end
            @(negedge clk);
        end
        row_ready = 1'b0;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            n_cmp++;
            if ({busy1, valid1, bits1, addr1} !== 31'd0) begin
                n_err++;
                $display("FAIL reset_dut1 cycle %0d: busy=%b valid=%b bits=%h addr=%h want all 0",
                         k, busy1, valid1, bits1, addr1);
            end
            n_cmp++;
            if ({busy3, valid3, bits3, addr3} !== 31'd0) begin
                n_err++;
                $display("FAIL reset_dut3 cycle %0d: busy=%b valid=%b bits=%h addr=%h want all 0",
                         k, busy3, valid3, bits3, addr3);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_basic();
        fill_mem(0);
        fetch_check(1'b0, 13'h0400, 5'd3, 0, 0, "basic");
    endtask

    task automatic test_backpressure();
        fill_mem(0);
        fetch_check(1'b0, 13'h0400, 5'd3, 31, 22, "backpressure");
    endtask

    task automatic test_wrap();
        fill_mem(3);
        fetch_check(1'b0, 13'h1E00, 5'd31, 0, 0, "wrap_top_row");
        fetch_check(1'b0, 13'h1FF8, 5'd0, 0, 0, "wrap_mod8192");
    endtask

    task automatic test_latency3();
        fill_mem(1);
        fetch_check(1'b1, 13'h0600, 5'd7, 0, 0, "lat3_ones");
        fill_mem(2);
        mem[pix_addr(13'h0A00, 5'd12, 0)] = 1'b1;
        fetch_check(1'b1, 13'h0A00, 5'd12, 0, 0, "lat3_msb");
    endtask

    task automatic test_reset_mid();
        fill_mem(1);
        @(negedge clk);
        offset = 13'h0200;
        row    = 5'd9;
        req1   = 1'b1;
        @(negedge clk);
        req1 = 1'b0;
        repeat (7) @(negedge clk);
        // After edge 7 columns 0..5 have been captured from an all-ones ROM.
        n_cmp++;
        if (bits1 !== 16'hFC00) begin
            n_err++;
            $display("FAIL reset_mid partial_bits: got %h want %h", bits1, 16'hFC00);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy1, valid1, bits1, addr1} !== 31'd0) begin
            n_err++;
            $display("FAIL reset_mid async_clear: busy=%b valid=%b bits=%h addr=%h want all 0",
                     busy1, valid1, bits1, addr1);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fill_mem(3);
        fetch_check(1'b0, 13'h0200, 5'd9, 0, 0, "after_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            fill_mem(3);
            fetch_check(1'($urandom_range(0, 1)), 13'($urandom), 5'($urandom),
                        int'($urandom_range(0, 26)), int'($urandom_range(2, 17)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_latency3();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/font_row_fetcher.md
Name: font_row_fetcher

Overview:
- Consumer-side counterpart of the switch-driven glyph offset: takes a 13-bit glyph base offset (character index × 0x200) plus a scanline row, and reads that glyph row out of the 1-bit-wide font ROM.
- Assembles the row into a parallel pixel word and hands it to the overlay pixel path over a valid/ready handshake.
- Sits between the offset source and the font ROM inside the font engine, one request per scanline row.

Parameters:
- GLYPH_W, 16, pixels per glyph row (bits fetched per request)
- GLYPH_H, 32, rows per glyph; GLYPH_W × GLYPH_H = 512 = glyph stride 0x200
- ROM_LAT, 1, font ROM read latency in clocks (1..3 supported)

Ports:
- clk_50MHz  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req  in  1  fetch request, sampled only while busy=0
- offset  in  13  glyph base bit-address (multiple of 0x200 in normal use)
- row  in  5  glyph row index 0..GLYPH_H-1
- busy  out  1  high from request acceptance until handshake completes
- rom_addr  out  13  font ROM bit address
- rom_data  in  1  font ROM data, valid ROM_LAT clocks after rom_addr
- row_bits  out  16  assembled pixel row; bit 15 = leftmost pixel (column 0)
- row_valid  out  1  row_bits valid
- row_ready  in  1  downstream accepts row_bits

Behaviour:
- Clock/reset: one clock, clk_50MHz. rst_n is asynchronous and active-low. While rst_n=0: state=IDLE, busy=0, row_valid=0, row_bits=0, rom_addr=0, all counters cleared.
- Reset mid-operation aborts the fetch with no partial output. ROM data still in flight is discarded.
- FSM states: IDLE, FETCH, WAIT, HOLD.
- IDLE:
  - On req=1, latch offset and row, clear row_bits, set busy=1, go to FETCH.
  - req is ignored in every other state; no queuing.
- FETCH: lasts GLYPH_W cycles.
  - In column cycle c (0..15), rom_addr = offset + row*GLYPH_W + c.
  - Sum is computed in 13 bits and wraps modulo 8192. There is no error on a non-aligned offset or wrap.
  - After c=15, go to WAIT.
- Data capture:
  - Column c's data is captured ROM_LAT cycles after its address is presented.
  - It is written to row_bits[15-c]. The capture pipeline is a ROM_LAT-deep shift of (valid, column index).
- WAIT: lasts until the last column's data is captured, i.e. ROM_LAT cycles after the final address. Then row_valid=1 and go to HOLD.
- HOLD:
  - row_valid and row_bits stay stable until row_ready=1.
  - On the cycle with row_valid=1 and row_ready=1: next cycle row_valid=0, busy=0, state=IDLE.
  - row_bits keeps its last value until the next accept.
- Latency, req accepted at edge 0:
  - First address is driven during cycle 1.
  - Last address is driven during cycle 16.
  - row_valid rises at edge 17+ROM_LAT (18 for ROM_LAT=1).
  - With row_ready held high, busy falls one cycle after row_valid rises.
  - Minimum request spacing is 19 cycles for ROM_LAT=1.
- rom_addr holds its last value outside FETCH.
- row_ready asserted while row_valid=0 has no effect.
- row > GLYPH_H-1 cannot occur with a 5-bit row and GLYPH_H=32. For other GLYPH_H values the row index is not range-checked; the address simply wraps.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles, release with req=0 → busy=0, row_valid=0, row_bits=16'h0000, rom_addr=0 for 20 cycles.
- Basic fetch: ROM model (ROM_LAT=1) returns bit = addr[0]; req with offset=13'h0400, row=3.
  - rom_addr steps 13'h0430..13'h043F on cycles 1..16.
  - row_valid rises at cycle 18 with row_bits=16'h5555.
  - busy drops at cycle 19 (row_ready=1).
- Backpressure: same as basic fetch but row_ready=0 until cycle 30.
  - row_valid=1 and row_bits stable cycles 18..30.
  - A second req at cycle 22 is ignored (rom_addr unchanged).
  - busy=0 at cycle 31.
- Wrap-around: offset=13'h1E00, row=31 → addresses 13'h1FF0..13'h1FFF with no wrap. Then offset=13'h1FF8, row=0 → addresses 13'h1FF8..13'h1FFF then 13'h0000..13'h0007.
- Latency parameter: ROM_LAT=3 and ROM model returning all ones → row_bits=16'hFFFF, row_valid at cycle 20. ROM model returning 1 only at column 0 → row_bits=16'h8000 (MSB orientation).
- Reset mid-fetch: assert rst_n=0 at cycle 8 of FETCH → busy, row_valid, row_bits immediately 0. After release, a new req fetches correctly with no stale bits.
